// File: rtl/doorlock_ctrl.sv
// Passcode door-lock controller: DIGITS-long BCD entry, timed door-open pulse, lockout after MAX_FAIL failures.
// Optional passcode change (OPEN -> PROG) is compiled in when DOORLOCK_PWCHG_EN is defined.
module doorlock_ctrl #(
  parameter int                  DIGITS   = 4,
  parameter int                  MAX_FAIL = 3,
  parameter int                  OPEN_CYC = 1000,
  parameter int                  LOCK_CYC = 5000,
  parameter logic [4*DIGITS-1:0] PW_INIT  = 16'h1234
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps_start,
  input  logic [3:0]                    ps_num,
  input  logic                          ps_valid,
  input  logic                          ps_end,
  output logic                          door_open,
  output logic                          alarm,
  output logic [2:0]                    state,
  output logic [1:0]                    seg_out,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

  localparam int BW   = 4 * DIGITS;
  localparam int CW   = $clog2(DIGITS + 1);
  localparam int FW   = $clog2(MAX_FAIL + 1);
  localparam int TMAX = (OPEN_CYC > LOCK_CYC) ? OPEN_CYC : LOCK_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_OPEN  = 3'd2,
    S_LOCK  = 3'd3,
    S_PROG  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [FW-1:0]   fail_q, fail_d;
  logic            err_q, err_d;
  logic            door_q, door_d;
  logic            alarm_q, alarm_d;
  logic [1:0]      seg_q, seg_d;
  logic [BW-1:0]   pw_s;
  logic            digit_ok_s;
  logic            full_s;
  logic [FW-1:0]   fail_inc_s;

`ifdef DOORLOCK_PWCHG_EN
  logic [BW-1:0]   pw_q, pw_d;
  assign pw_s = pw_q;
`else
  assign pw_s = PW_INIT;
`endif

  assign full_s     = (cnt_q == CW'(DIGITS));
  assign digit_ok_s = ps_valid && (ps_num <= 4'd9) && !full_s;
  assign fail_inc_s = (fail_q == FW'(MAX_FAIL)) ? fail_q : fail_q + 1'b1;

  // State and datapath registers; reset also reloads the stored code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      fail_q  <= '0;
      err_q   <= 1'b0;
      door_q  <= 1'b0;
      alarm_q <= 1'b0;
      seg_q   <= 2'd0;
`ifdef DOORLOCK_PWCHG_EN
      pw_q    <= PW_INIT;
`endif
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      door_q  <= door_d;
      alarm_q <= alarm_d;
      seg_q   <= seg_d;
`ifdef DOORLOCK_PWCHG_EN
      pw_q    <= pw_d;
`endif
    end
  end

  // Next-state logic; outputs are decoded from the next state so they register alongside it.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    fail_d  = fail_q;
    err_d   = err_q;
`ifdef DOORLOCK_PWCHG_EN
    pw_d    = pw_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (ps_start) begin
          state_d = S_ENTRY;
          buf_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ENTRY: begin
        if (ps_start) begin
          buf_d = '0;
          cnt_d = '0;
        end else if (ps_end) begin
          if (full_s && (buf_q == pw_s)) begin
            state_d = S_OPEN;
            fail_d  = '0;
            tmr_d   = '0;
          end else begin
            fail_d = fail_inc_s;
            if (fail_inc_s == FW'(MAX_FAIL)) begin
              state_d = S_LOCK;
              tmr_d   = '0;
            end else begin
              state_d = S_IDLE;
              err_d   = 1'b1;
            end
          end
        end else if (digit_ok_s) begin
          buf_d = (buf_q << 4'd4) | BW'(ps_num);
          cnt_d = cnt_q + 1'b1;
        end else begin
          state_d = S_ENTRY;
        end
      end
      S_OPEN: begin
`ifdef DOORLOCK_PWCHG_EN
        if (ps_start) begin
          state_d = S_PROG;
          buf_d   = '0;
          cnt_d   = '0;
        end else
`endif
        if (ps_end) begin
          state_d = S_IDLE;
        end else if (tmr_q == TW'(OPEN_CYC - 1)) begin
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_LOCK: begin
        if (tmr_q == TW'(LOCK_CYC - 1)) begin
          state_d = S_IDLE;
          fail_d  = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
`ifdef DOORLOCK_PWCHG_EN
      S_PROG: begin
        if (ps_start) begin
          buf_d = '0;
          cnt_d = '0;
        end else if (ps_end) begin
          state_d = S_IDLE;
          if (full_s) begin
            pw_d = buf_q;
          end else begin
            err_d = 1'b1;
          end
        end else if (digit_ok_s) begin
          buf_d = (buf_q << 4'd4) | BW'(ps_num);
          cnt_d = cnt_q + 1'b1;
        end else begin
          state_d = S_PROG;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    door_d  = (state_d == S_OPEN);
    alarm_d = (state_d == S_LOCK);
    case (state_d)
      S_OPEN:  seg_d = 2'd1;
      S_LOCK:  seg_d = 2'd3;
      S_PROG:  seg_d = 2'd0;
      default: seg_d = err_d ? 2'd2 : 2'd0;
    endcase
  end

  assign state     = state_q;
  assign door_open = door_q;
  assign alarm     = alarm_q;
  assign seg_out   = seg_q;
  assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_doorlock_ctrl.sv
// Directed self-checking bench for doorlock_ctrl (DIGITS=4, MAX_FAIL=3, OPEN_CYC=8, LOCK_CYC=16).
// Passcode-change scenario is exercised when DOORLOCK_PWCHG_EN is defined.
module tb_doorlock_ctrl;
  logic       clk;
  logic       rst;
  logic       ps_start;
  logic [3:0] ps_num;
  logic       ps_valid;
  logic       ps_end;
  logic       door_open;
  logic       alarm;
  logic [2:0] state;
  logic [1:0] seg_out;
  logic [1:0] fail_cnt;
  int checks;
  int failures;

  doorlock_ctrl #(
    .DIGITS(4), .MAX_FAIL(3), .OPEN_CYC(8), .LOCK_CYC(16), .PW_INIT(16'h1234)
  ) dut (
    .clk(clk), .rst(rst), .ps_start(ps_start), .ps_num(ps_num), .ps_valid(ps_valid),
    .ps_end(ps_end), .door_open(door_open), .alarm(alarm), .state(state),
    .seg_out(seg_out), .fail_cnt(fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ps_start = 1'b0; ps_valid = 1'b0; ps_end = 1'b0; ps_num = 4'd0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic start_p();
    ps_start = 1'b1; tick(); ps_start = 1'b0;
  endtask

  task automatic digit(input logic [3:0] d);
    ps_num = d; ps_valid = 1'b1; tick(); ps_valid = 1'b0;
  endtask

  task automatic end_p();
    ps_end = 1'b1; tick(); ps_end = 1'b0;
  endtask

  task automatic enter4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    start_p(); digit(a); digit(b); digit(c); digit(d); end_p();
  endtask

  task automatic test_reset();
    rst = 1'b1; ps_start = 1'b0; ps_valid = 1'b0; ps_end = 1'b0; ps_num = 4'd0;
    tick();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (door_open !== 1'b0 || alarm !== 1'b0) begin failures++; $display("FAIL reset_door_alarm got=%b%b exp=00", door_open, alarm); end
    checks++; if (seg_out !== 2'd0 || fail_cnt !== 2'd0) begin failures++; $display("FAIL reset_seg_fail got=%0d/%0d exp=0/0", seg_out, fail_cnt); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_correct_code();
    int n;
    do_reset();
    start_p();
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL entry_state got=%0d exp=1", state); end
    digit(4'd1); digit(4'd2); digit(4'd3); digit(4'd4); end_p();
    checks++; if (state !== 3'd2 || door_open !== 1'b1) begin failures++; $display("FAIL open_state got=%0d door=%b exp=2 door=1", state, door_open); end
    checks++; if (seg_out !== 2'd1) begin failures++; $display("FAIL open_seg got=%0d exp=1", seg_out); end
    n = 1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (door_open) n++; else break;
    end
    checks++; if (n !== 8) begin failures++; $display("FAIL open_len got=%0d exp=8", n); end
    checks++; if (state !== 3'd0 || seg_out !== 2'd0) begin failures++; $display("FAIL open_after got=%0d seg=%0d exp=0 seg=0", state, seg_out); end
  endtask

  task automatic test_wrong_code();
    do_reset();
    enter4(4'd1, 4'd2, 4'd3, 4'd5);
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL wrong_state got=%0d exp=0", state); end
    checks++; if (seg_out !== 2'd2) begin failures++; $display("FAIL wrong_seg got=%0d exp=2", seg_out); end
    checks++; if (fail_cnt !== 2'd1) begin failures++; $display("FAIL wrong_cnt got=%0d exp=1", fail_cnt); end
    tick();
    checks++; if (seg_out !== 2'd2) begin failures++; $display("FAIL wrong_seg_held got=%0d exp=2", seg_out); end
    start_p();
    checks++; if (seg_out !== 2'd0 || state !== 3'd1) begin failures++; $display("FAIL wrong_clear got seg=%0d st=%0d exp seg=0 st=1", seg_out, state); end
  endtask

  task automatic test_lockout();
    int n;
    do_reset();
    enter4(4'd1, 4'd2, 4'd3, 4'd5);
    enter4(4'd9, 4'd9, 4'd9, 4'd9);
    checks++; if (fail_cnt !== 2'd2 || state !== 3'd0) begin failures++; $display("FAIL lock_pre got cnt=%0d st=%0d exp cnt=2 st=0", fail_cnt, state); end
    enter4(4'd0, 4'd0, 4'd0, 4'd0);
    checks++; if (state !== 3'd3 || alarm !== 1'b1 || seg_out !== 2'd3) begin failures++; $display("FAIL lock_enter got st=%0d al=%b seg=%0d exp st=3 al=1 seg=3", state, alarm, seg_out); end
    checks++; if (fail_cnt !== 2'd3) begin failures++; $display("FAIL lock_cnt got=%0d exp=3", fail_cnt); end
    n = 1;
    for (int i = 0; i < 40; i++) begin
      ps_valid = (i < 4); ps_num = 4'd1; ps_start = (i == 1); ps_end = (i == 2);
      tick();
      ps_valid = 1'b0; ps_start = 1'b0; ps_end = 1'b0;
      if (alarm) n++; else break;
    end
    checks++; if (n !== 16) begin failures++; $display("FAIL lock_len got=%0d exp=16", n); end
    checks++; if (state !== 3'd0 || fail_cnt !== 2'd0 || seg_out !== 2'd0) begin failures++; $display("FAIL lock_after got st=%0d cnt=%0d seg=%0d exp 0/0/0", state, fail_cnt, seg_out); end
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL lock_reopen got=%0d exp=2", state); end
  endtask

  task automatic test_boundary();
    do_reset();
    start_p();
    digit(4'd1); digit(4'd2); digit(4'hA); digit(4'd3); digit(4'd4); digit(4'd5);
    end_p();
    checks++; if (state !== 3'd2 || door_open !== 1'b1) begin failures++; $display("FAIL bound_open got st=%0d door=%b exp st=2 door=1", state, door_open); end
    tick();
    end_p();
    checks++; if (state !== 3'd0 || door_open !== 1'b0) begin failures++; $display("FAIL early_close got st=%0d door=%b exp st=0 door=0", state, door_open); end
    start_p(); digit(4'd1); digit(4'd2); digit(4'd3); end_p();
    checks++; if (state !== 3'd0 || seg_out !== 2'd2 || fail_cnt !== 2'd1) begin failures++; $display("FAIL short_entry got st=%0d seg=%0d cnt=%0d exp 0/2/1", state, seg_out, fail_cnt); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    start_p(); digit(4'd1); digit(4'd2); digit(4'd3);
    ps_num = 4'd4; ps_valid = 1'b1; ps_end = 1'b1;
    tick();
    ps_valid = 1'b0; ps_end = 1'b0;
    checks++; if (state !== 3'd0 || fail_cnt !== 2'd1 || seg_out !== 2'd2) begin failures++; $display("FAIL valid_end got st=%0d cnt=%0d seg=%0d exp 0/1/2", state, fail_cnt, seg_out); end
    start_p(); digit(4'd1); digit(4'd2); digit(4'd3); digit(4'd4);
    ps_start = 1'b1; ps_end = 1'b1;
    tick();
    ps_start = 1'b0; ps_end = 1'b0;
    checks++; if (state !== 3'd1 || fail_cnt !== 2'd1) begin failures++; $display("FAIL start_end got st=%0d cnt=%0d exp st=1 cnt=1", state, fail_cnt); end
    end_p();
    checks++; if (fail_cnt !== 2'd2) begin failures++; $display("FAIL restart_cleared got cnt=%0d exp=2", fail_cnt); end
  endtask

  task automatic test_reset_open();
    do_reset();
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    tick(); tick();
    rst = 1'b1;
    #1;
    checks++; if (door_open !== 1'b0 || state !== 3'd0) begin failures++; $display("FAIL rst_async got door=%b st=%0d exp door=0 st=0", door_open, state); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (door_open !== 1'b0 || state !== 3'd0 || seg_out !== 2'd0) begin failures++; $display("FAIL rst_open got door=%b st=%0d seg=%0d exp 0/0/0", door_open, state, seg_out); end
  endtask

`ifdef DOORLOCK_PWCHG_EN
  task automatic test_pwchg();
    do_reset();
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    start_p();
    checks++; if (state !== 3'd4 || door_open !== 1'b0 || seg_out !== 2'd0) begin failures++; $display("FAIL prog_enter got st=%0d door=%b seg=%0d exp 4/0/0", state, door_open, seg_out); end
    digit(4'd9); digit(4'd8); digit(4'd7); digit(4'd6); end_p();
    checks++; if (state !== 3'd0 || seg_out !== 2'd0) begin failures++; $display("FAIL prog_done got st=%0d seg=%0d exp 0/0", state, seg_out); end
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    checks++; if (state !== 3'd0 || fail_cnt !== 2'd1) begin failures++; $display("FAIL prog_old got st=%0d cnt=%0d exp 0/1", state, fail_cnt); end
    enter4(4'd9, 4'd8, 4'd7, 4'd6);
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL prog_new got st=%0d exp=2", state); end
    do_reset();
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL prog_rst_reload got st=%0d exp=2", state); end
  endtask
`else
  task automatic test_back_to_back();
    do_reset();
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    start_p();
    checks++; if (state !== 3'd2 || door_open !== 1'b1) begin failures++; $display("FAIL open_start_ignored got st=%0d door=%b exp 2/1", state, door_open); end
    end_p();
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    checks++; if (state !== 3'd2 || fail_cnt !== 2'd0) begin failures++; $display("FAIL b2b_reopen got st=%0d cnt=%0d exp 2/0", state, fail_cnt); end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_correct_code();
    test_wrong_code();
    test_lockout();
    test_boundary();
    test_simultaneous();
    test_reset_open();
`ifdef DOORLOCK_PWCHG_EN
    test_pwchg();
`else
    test_back_to_back();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
